// File: rtl/read_ptr_level_ctrl.sv
// read_ptr_level_ctrl
// Read-domain pointer and flag controller for the asynchronous FIFO.
// Holds the binary and Gray read pointers. It converts the synchronised Gray
// write pointer back to binary and registers these outputs:
//   - the fill level
//   - the empty flag
//   - a programmable almost-empty flag
//
// Optional build macro: READ_PTR_UNDERFLOW_DET_EN
//   Adds a sticky flag that records a pop attempted while the FIFO was empty.
//
// Ports:
//   read_clk        read-domain clock
//   read_rst        asynchronous active-low reset
//   read_inc        pop request, honoured only while rempty=0
//   rq2_write_ptr   Gray write pointer, already synchronised into read_clk
//   ae_thresh       new almost-empty threshold
//   ae_thresh_load  capture ae_thresh on this edge
//   runderflow_clr  clear the sticky underflow flag (macro builds only)
//   read_addr       RAM read address (low bits of the binary read pointer)
//   read_ptr        registered Gray read pointer, sent to the write domain
//   rempty          registered empty flag
//   ralmost_empty   registered flag, set when level <= threshold
//   rlevel          registered occupancy, 0..2**ADDRESS_BITS
//   runderflow      sticky underflow flag, constant 0 without the macro
module read_ptr_level_ctrl #(
  parameter int ADDRESS_BITS = 4,
  parameter int AE_DEFAULT   = 2
) (
  input  logic                    read_clk,
  input  logic                    read_rst,
  input  logic                    read_inc,
  input  logic [ADDRESS_BITS:0]   rq2_write_ptr,
  input  logic [ADDRESS_BITS:0]   ae_thresh,
  input  logic                    ae_thresh_load,
  input  logic                    runderflow_clr,
  output logic [ADDRESS_BITS-1:0] read_addr,
  output logic [ADDRESS_BITS:0]   read_ptr,
  output logic                    rempty,
  output logic                    ralmost_empty,
  output logic [ADDRESS_BITS:0]   rlevel,
  output logic                    runderflow
);

  localparam int PW = ADDRESS_BITS + 1;

  logic [PW-1:0] rbin;
  logic [PW-1:0] rbinnext;
  logic [PW-1:0] rgraynext;
  logic [PW-1:0] wbin_s;
  logic [PW-1:0] level_next;
  logic [PW-1:0] thresh_reg;
  logic          pop;

  assign pop       = read_inc & ~rempty;
  assign rbinnext  = rbin + {{ADDRESS_BITS{1'b0}}, pop};
  assign rgraynext = (rbinnext >> 1) ^ rbinnext;
  assign read_addr = rbin[ADDRESS_BITS-1:0];

  // Gray to binary: each binary bit is the XOR of all Gray bits at or above it.
  always_comb begin
    wbin_s = '0;
    for (int i = 0; i < PW; i++) begin
      wbin_s[i] = ^(rq2_write_ptr >> i);
    end
  end

  // The extra pointer MSB keeps the modular difference correct across wrap,
  // so a full FIFO reads as 2**ADDRESS_BITS and not as 0.
  assign level_next = wbin_s - rbinnext;

  always_ff @(posedge read_clk or negedge read_rst) begin
    if (!read_rst) begin
      rbin          <= '0;
      read_ptr      <= '0;
      rempty        <= 1'b1;
      ralmost_empty <= 1'b1;
      rlevel        <= '0;
    end else begin
      rbin          <= rbinnext;
      read_ptr      <= rgraynext;
      rempty        <= (rgraynext == rq2_write_ptr);
      ralmost_empty <= (level_next <= thresh_reg);
      rlevel        <= level_next;
    end
  end

  // A newly loaded threshold is first used by the flag computed one edge later.
  always_ff @(posedge read_clk or negedge read_rst) begin
    if (!read_rst) begin
      thresh_reg <= PW'(AE_DEFAULT);
    end else if (ae_thresh_load) begin
      thresh_reg <= ae_thresh;
    end
  end

`ifdef READ_PTR_UNDERFLOW_DET_EN
  // A set request takes priority over a clear arriving on the same edge.
  always_ff @(posedge read_clk or negedge read_rst) begin
    if (!read_rst) begin
      runderflow <= 1'b0;
    end else if (read_inc && rempty) begin
      runderflow <= 1'b1;
    end else if (runderflow_clr) begin
      runderflow <= 1'b0;
    end
  end
`else
  logic unused_runderflow_clr;
  assign unused_runderflow_clr = runderflow_clr;
  assign runderflow            = 1'b0;
`endif

endmodule

// File: tb/tb_read_ptr_level_ctrl.sv
module tb_read_ptr_level_ctrl;

  localparam int AB    = 4;
  localparam int PW    = AB + 1;
  localparam int DEPTH = 1 << AB;

  logic          read_clk = 1'b0;
  logic          read_rst = 1'b0;
  logic          read_inc = 1'b0;
  logic [PW-1:0] rq2_write_ptr = '0;
  logic [PW-1:0] ae_thresh = '0;
  logic          ae_thresh_load = 1'b0;
  logic          runderflow_clr = 1'b0;
  logic [AB-1:0] read_addr;
  logic [PW-1:0] read_ptr;
  logic          rempty;
  logic          ralmost_empty;
  logic [PW-1:0] rlevel;
  logic          runderflow;

  read_ptr_level_ctrl #(.ADDRESS_BITS(AB), .AE_DEFAULT(2)) dut (
    .read_clk       (read_clk),
    .read_rst       (read_rst),
    .read_inc       (read_inc),
    .rq2_write_ptr  (rq2_write_ptr),
    .ae_thresh      (ae_thresh),
    .ae_thresh_load (ae_thresh_load),
    .runderflow_clr (runderflow_clr),
    .read_addr      (read_addr),
    .read_ptr       (read_ptr),
    .rempty         (rempty),
    .ralmost_empty  (ralmost_empty),
    .rlevel         (rlevel),
    .runderflow     (runderflow)
  );

  always #5 read_clk = ~read_clk;

  typedef struct {
    logic [AB-1:0] addr;
    logic [PW-1:0] ptr;
    logic          empty;
    logic          ae;
    logic [PW-1:0] level;
    logic          uf;
  } exp_t;

  exp_t sb[$];

  int tests = 0;
  int fails = 0;

  // Reference model: words are counted as unbounded totals written and read.
  int rd_cnt  = 0;
  int wr_cnt  = 0;
  int thr_cur = 2;
  bit m_empty = 1'b1;
  bit m_uf    = 1'b0;

  function automatic logic [PW-1:0] to_gray(input int v);
    logic [PW-1:0] b;
    b = v[PW-1:0];
    return b ^ (b >> 1);
  endfunction

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_reset();
    check("rst_read_addr", int'(read_addr), 0);
    check("rst_read_ptr", int'(read_ptr), 0);
    check("rst_rempty", int'(rempty), 1);
    check("rst_ralmost_empty", int'(ralmost_empty), 1);
    check("rst_rlevel", int'(rlevel), 0);
    check("rst_runderflow", int'(runderflow), 0);
  endtask

  task automatic model_reset();
    rd_cnt  = 0;
    wr_cnt  = 0;
    thr_cur = 2;
    m_empty = 1'b1;
    m_uf    = 1'b0;
  endtask

  // Drive one cycle of stimulus and queue the response expected after the next edge.
  task automatic step(input bit inc, input int adv, input bit load, input int thr, input bit clr);
    exp_t e;
    int   level;
    @(negedge read_clk);
    read_inc       = inc;
    wr_cnt         = wr_cnt + adv;
    rq2_write_ptr  = to_gray(wr_cnt);
    ae_thresh_load = load;
    ae_thresh      = thr[PW-1:0];
    runderflow_clr = clr;
    if (inc && m_empty) m_uf = 1'b1;
    else if (clr) m_uf = 1'b0;
    if (inc && !m_empty) rd_cnt++;
    level   = wr_cnt - rd_cnt;
    e.addr  = rd_cnt[AB-1:0];
    e.ptr   = to_gray(rd_cnt);
    e.empty = (level == 0);
    e.ae    = (level <= thr_cur);
    e.level = level[PW-1:0];
`ifdef READ_PTR_UNDERFLOW_DET_EN
    e.uf    = m_uf;
`else
    e.uf    = 1'b0;
`endif
    m_empty = e.empty;
    if (load) thr_cur = thr;
    sb.push_back(e);
  endtask

  task automatic random_steps(input int n);
    int room;
    int adv;
    for (int i = 0; i < n; i++) begin
      room = DEPTH - (wr_cnt - rd_cnt);
      adv  = (room == 0) ? 0 : $urandom_range(0, (room < 2) ? room : 2);
      step($urandom_range(0, 3) != 0, adv, $urandom_range(0, 15) == 0,
           $urandom_range(0, 31), $urandom_range(0, 7) == 0);
    end
  endtask

  always @(posedge read_clk) begin
    exp_t e;
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check("read_addr", int'(read_addr), int'(e.addr));
      check("read_ptr", int'(read_ptr), int'(e.ptr));
      check("rempty", int'(rempty), int'(e.empty));
      check("ralmost_empty", int'(ralmost_empty), int'(e.ae));
      check("rlevel", int'(rlevel), int'(e.level));
      check("runderflow", int'(runderflow), int'(e.uf));
    end
  end

  initial begin
    model_reset();
    wr_cnt        = 5;
    rq2_write_ptr = to_gray(wr_cnt);
    #12;
    check_reset();
    @(posedge read_clk);
    #2 read_rst = 1'b1;

    step(0, 0, 0, 0, 0);                          // level 5
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0);  // levels 4,3,2
    for (int i = 0; i < 2; i++) step(1, 0, 0, 0, 0);  // drain to empty
    for (int i = 0; i < 2; i++) step(1, 0, 0, 0, 0);  // pops ignored
    step(1, 0, 0, 0, 1);                          // set wins over clear
    step(0, 0, 0, 0, 1);                          // clear alone

    step(0, 11, 0, 0, 0);                         // write total 16, level 11
    for (int i = 0; i < 10; i++) step(1, 0, 0, 0, 0); // read total 15, level 1
    step(1, 0, 0, 0, 0);                          // pointer reaches 16, empty

    step(0, 10, 0, 0, 0);                         // level 10
    step(0, 0, 1, 8, 0);                          // load threshold 8
    step(1, 0, 0, 0, 0);                          // level 9
    step(1, 0, 0, 0, 0);                          // level 8

    for (int i = 0; i < 7; i++) step(1, 0, 0, 0, 0);  // level 1
    step(1, 1, 0, 0, 0);                          // pop last word with a write
    step(1, 0, 0, 0, 0);                          // empty
    step(0, 16, 0, 0, 0);                         // full
    step(0, 0, 1, 31, 0);                         // threshold above depth
    step(0, 0, 0, 0, 0);

    random_steps(3000);

    @(negedge read_clk);
    read_rst       = 1'b0;
    read_inc       = 1'b0;
    ae_thresh_load = 1'b0;
    runderflow_clr = 1'b0;
    model_reset();
    rq2_write_ptr  = to_gray(wr_cnt);
    #1;
    check_reset();
    @(posedge read_clk);
    #2 read_rst = 1'b1;
    step(1, 3, 0, 0, 0);                          // pop while still empty is ignored
    step(1, 0, 0, 0, 0);
    random_steps(500);

    repeat (3) @(posedge read_clk);
    #2;
    check("scoreboard_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/read_ptr_level_ctrl.md
Name: read_ptr_level_ctrl

Overview:
- Read-domain pointer/flag controller for the asynchronous FIFO; parametrised successor to the basic read-pointer/empty block.
- Keeps the binary and Gray read pointers and the registered empty flag.
- Adds a gray-to-binary conversion of the synchronised write pointer, a registered fill level and a programmable almost-empty flag.
- Sits in the read_clk domain, between the two-flop write-pointer synchroniser and the dual-port RAM read port.

Parameters:
- ADDRESS_BITS, 4, RAM address width; FIFO depth = 2**ADDRESS_BITS; pointers are ADDRESS_BITS+1 bits.
- AE_DEFAULT, 2, almost-empty threshold used while ae_thresh_load has never been asserted since reset.

Ports:
- read_clk  input  1  read-domain clock.
- read_rst  input  1  asynchronous active-low reset.
- read_inc  input  1  pop request; honoured only when rempty=0.
- rq2_write_ptr  input  ADDRESS_BITS+1  write pointer (Gray), already synchronised into read_clk.
- ae_thresh  input  ADDRESS_BITS+1  new almost-empty threshold.
- ae_thresh_load  input  1  latch ae_thresh on this edge.
- runderflow_clr  input  1  clear the sticky underflow flag (macro builds only).
- read_addr  output  ADDRESS_BITS  RAM read address = rbin[ADDRESS_BITS-1:0].
- read_ptr  output  ADDRESS_BITS+1  registered Gray read pointer, sent to the write-domain synchroniser.
- rempty  output  1  registered empty flag.
- ralmost_empty  output  1  registered, asserted when level <= threshold.
- rlevel  output  ADDRESS_BITS+1  registered occupancy, range 0..2**ADDRESS_BITS.
- runderflow  output  1  sticky underflow flag; tied 0 when the macro is absent.

Behaviour:
- Reset (read_rst=0, asynchronous):
  - rbin=0, read_ptr=0, read_addr=0, rempty=1, ralmost_empty=1, rlevel=0, runderflow=0.
  - Threshold register = AE_DEFAULT.
- Pop: rbinnext = rbin + (read_inc & ~rempty). Read while empty is ignored; the pointers hold.
- Gray: rgraynext = (rbinnext>>1) ^ rbinnext. On every edge, {rbin, read_ptr} <= {rbinnext, rgraynext}.
- Write-pointer conversion: wbin_s is the combinational gray-to-binary of rq2_write_ptr (prefix XOR from the MSB down).
- Level:
  - level_next = wbin_s - rbinnext, modulo 2**(ADDRESS_BITS+1). Correct across pointer wrap because of the extra MSB.
  - rlevel <= level_next.
- Empty: rempty <= (rgraynext == rq2_write_ptr), i.e. level_next==0.
- Almost-empty: ralmost_empty <= (level_next <= thresh_reg), unsigned compare.
- Timing: all flags and rlevel update on the same edge as read_ptr, so one cycle after a pop or a wptr change. No combinational path from inputs to outputs.
- Threshold register:
  - ae_thresh_load=1 captures ae_thresh; the new value takes effect in the flag computed on the next edge.
  - Values above 2**ADDRESS_BITS make ralmost_empty permanently 1. This is legal and not flagged.
- Boundaries:
  - Wrap: rbin 2**(ADDRESS_BITS+1)-1 -> 0 is natural rollover; read_addr wraps at depth.
  - Simultaneous pop of the last word and wptr advance: level_next reflects both, and rempty follows level_next.
  - rq2_write_ptr appearing to move backwards (only under a synchroniser fault) is not detected.
- Reset mid-operation: all state returns to reset values immediately; the first pop is accepted only after rempty deasserts.

Optional Feature:
- Macro: READ_PTR_UNDERFLOW_DET_EN.
- Defined:
  - runderflow <= 1 on any edge where read_inc=1 and rempty=1, and stays set.
  - runderflow_clr=1 clears it; if set and clear occur on the same edge, set wins.
- Not defined: runderflow is constant 0, runderflow_clr is ignored, and no flop is inferred.
- The pointer behaviour is identical in both builds.

Test Plan:
- Reset, ADDRESS_BITS=4, rq2_write_ptr=5'b00111 (bin 5) from cycle 0, release reset -> after one edge rlevel=5, rempty=0, ralmost_empty=0 (threshold 2).
- From the previous state, assert read_inc for 3 cycles -> read_addr steps 0,1,2,3; rlevel 4,3,2; ralmost_empty=1 after the third pop.
- Pop the remaining 2 words with read_inc held high -> rempty=1, rlevel=0. Further read_inc leaves read_addr=5 and read_ptr=5'b00111.
- Wrap: rbin=15 (read_ptr 5'b01000), rq2_write_ptr=5'b11000 (bin 16) -> rlevel=1. One pop gives read_ptr=5'b11000, read_addr=0, rempty=1.
- Load ae_thresh=8 when rlevel=10, then pop twice -> ralmost_empty stays 0 at level 9 and goes to 1 on the edge where level reaches 8.
- With READ_PTR_UNDERFLOW_DET_EN: read_inc while empty -> runderflow=1 next cycle. runderflow_clr together with another empty read keeps it 1; clr alone returns it to 0. Without the macro, runderflow stays 0 throughout.
